// File: rtl/reset_sequencer_pkg.sv
// Shared types and codes for the staged reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/ack and staged reset outputs of the reset sequencer.
interface reset_sequencer_if #(
  parameter int N_STAGES = 4
);
  logic                Btn_Reset_L;
  logic                Sw_Reset_Req;
  logic                Sw_Reset_Ack;
  logic [N_STAGES-1:0] Stage_Reset_L;
  logic                Ready;
  logic [1:0]          Reset_Cause;
  logic [7:0]          Reset_Count;

  modport master (
    input  Btn_Reset_L, Sw_Reset_Req,
    output Sw_Reset_Ack, Stage_Reset_L, Ready, Reset_Cause, Reset_Count
  );

  modport slave (
    output Btn_Reset_L, Sw_Reset_Req,
    input  Sw_Reset_Ack, Stage_Reset_L, Ready, Reset_Cause, Reset_Count
  );
endinterface

// File: rtl/reset_sequencer_reset_sync.sv
// Two-flop synchronizer on the falling clock edge: async assert to RST_VAL, sync release.
module reset_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/reset_sequencer.sv
// Turns board reset, reset button and software requests into staged active-low resets.
//   state   | meaning
//   HOLD    | all stages held in reset, timer counts HOLD_CYCLES edges
//   RELEASE | stages released one per STAGE_GAP edges, bit 0 first
//   RUN     | all stages released, button/software requests accepted
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_STAGES    = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGE_GAP   = 2,
  parameter int BTN_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             Reset_L,
  reset_sequencer_if.master bus
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] BTN_LAST  = CNT_W'(BTN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BTN_MAX   = CNT_W'(BTN_CYCLES);

  logic rst_int_n;
  logic btn_s;

  reset_sync #(.RST_VAL(1'b0)) u_por_sync (
    .clk(CLK), .rst_n(Reset_L), .d(1'b1), .q(rst_int_n)
  );

  // Idle level of the button is high, so the synchronizer resets to "not pressed".
  reset_sync #(.RST_VAL(1'b1)) u_btn_sync (
    .clk(CLK), .rst_n(Reset_L), .d(bus.Btn_Reset_L), .q(btn_s)
  );

  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    timer_q, timer_nxt;
  logic [N_STAGES-1:0] stage_q, stage_nxt;
  logic                ack_q, ack_nxt;
  logic [1:0]          cause_q, cause_nxt;
  logic [7:0]          count_q, count_nxt;
  logic [CNT_W-1:0]    btn_cnt_q;
  logic                btn_req;
  logic                sw_req;

  always_ff @(negedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      btn_cnt_q <= '0;
    end else if (btn_s) begin
      btn_cnt_q <= '0;
    end else if (btn_cnt_q != BTN_MAX) begin
      btn_cnt_q <= btn_cnt_q + CNT_W'(1);
    end
  end

  // Fires only on the edge the count reaches BTN_CYCLES; saturation re-arms on release.
  assign btn_req = !btn_s && (btn_cnt_q == BTN_LAST) && (state_q == ST_RUN);
  assign sw_req  = bus.Sw_Reset_Req && (state_q == ST_RUN);

  always_ff @(negedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_HOLD;
      timer_q <= '0;
      stage_q <= '0;
      ack_q   <= 1'b0;
      cause_q <= CAUSE_POR;
      count_q <= '0;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
      stage_q <= stage_nxt;
      ack_q   <= ack_nxt;
      cause_q <= cause_nxt;
      count_q <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    stage_nxt = stage_q;
    ack_nxt   = 1'b0;
    cause_nxt = cause_q;
    count_nxt = count_q;
    case (state_q)
      ST_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          timer_nxt = '0;
          stage_nxt = N_STAGES'(1);
          state_nxt = (N_STAGES == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          timer_nxt = timer_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (timer_q == GAP_LAST) begin
          timer_nxt = '0;
          stage_nxt = (stage_q << 1) | N_STAGES'(1);
          if (&stage_nxt) state_nxt = ST_RUN;
        end else begin
          timer_nxt = timer_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (sw_req || btn_req) begin
          state_nxt = ST_HOLD;
          timer_nxt = '0;
          stage_nxt = '0;
          ack_nxt   = sw_req;
          cause_nxt = sw_req ? CAUSE_SW : CAUSE_BTN;
          count_nxt = sat_inc8(count_q);
        end
      end
      default: begin
        state_nxt = ST_HOLD;
        timer_nxt = '0;
        stage_nxt = '0;
      end
    endcase
  end

  assign bus.Sw_Reset_Ack  = ack_q;
  assign bus.Stage_Reset_L = stage_q;
  assign bus.Ready         = (state_q == ST_RUN);
  assign bus.Reset_Cause   = cause_q;
  assign bus.Reset_Count   = count_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: power-on table, directed corner sequences, randomized run vs model.
module tb_reset_sequencer;
  localparam int N      = 4;
  localparam int HOLD   = 10;
  localparam int GAP    = 2;
  localparam int BTN    = 10;
  localparam int T_LAST = HOLD + (N - 1) * GAP;

  logic CLK     = 1'b1;
  logic Reset_L = 1'b1;

  reset_sequencer_if #(.N_STAGES(N)) bus();

  reset_sequencer #(
    .N_STAGES(N), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .BTN_CYCLES(BTN), .CNT_W(32)
  ) dut (
    .CLK(CLK), .Reset_L(Reset_L), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a sequence is anchored at an edge; stage i is released
  // HOLD + i*GAP edges after the anchor.
  int         k = 0;
  int         anchor = 0;
  int         rl_ones = 0;
  bit         active = 0;
  int         low_run = 0;
  bit         btn_q[$];
  logic [1:0] m_cause = 2'b00;
  int         m_count = 0;
  bit         m_ack = 0;

  typedef struct {
    logic       rl;
    logic [3:0] stage;
    logic       ready;
    logic [1:0] cause;
  } vec_t;
  vec_t por_tbl[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    rl_ones = 0;
    active  = 0;
    low_run = 0;
    btn_q.delete();
    btn_q.push_back(1'b1);
    btn_q.push_back(1'b1);
    m_cause = 2'b00;
    m_count = 0;
    m_ack   = 0;
  endtask

  task automatic model_edge(input logic rl, input logic btn, input logic sw);
    bit sb, run, breq, sreq;
    k++;
    sb = btn_q.pop_front();
    btn_q.push_back(rl ? btn : 1'b1);
    m_ack = 0;
    if (!rl) return;
    if (active) begin
      run = (k - 1 >= anchor + T_LAST);
      if (!sb) low_run++;
      else     low_run = 0;
      breq = !sb && (low_run == BTN) && run;
      sreq = sw && run;
      if (sreq || breq) begin
        anchor  = k;
        m_ack   = sreq;
        m_cause = sreq ? 2'b10 : 2'b01;
        if (m_count < 255) m_count++;
      end
    end else begin
      rl_ones++;
      if (rl_ones == 2) begin
        active = 1;
        anchor = k;
      end
    end
  endtask

  task automatic check_model();
    logic [15:0]  act, exp;
    logic [N-1:0] es;
    for (int i = 0; i < N; i++) es[i] = active && (k >= anchor + HOLD + i * GAP);
    exp = {es, active && (k >= anchor + T_LAST), m_ack, m_cause, 8'(m_count)};
    act = {bus.Stage_Reset_L, bus.Ready, bus.Sw_Reset_Ack, bus.Reset_Cause, bus.Reset_Count};
    check($sformatf("model_edge%0d", k), 32'(act), 32'(exp));
  endtask

  task automatic step(input logic btn, input logic sw);
    bus.Btn_Reset_L  = btn;
    bus.Sw_Reset_Req = sw;
    @(negedge CLK);
    model_edge(Reset_L, btn, sw);
    #1;
    check_model();
  endtask

  task automatic assert_reset();
    Reset_L = 1'b0;
    model_reset();
    #1;
    check_model();
  endtask

  task automatic run_until_ready(input string name, input int budget, output int n);
    n = 0;
    while (!bus.Ready && n < budget) begin
      step(1'b1, 1'b0);
      n++;
    end
    check(name, 32'(bus.Ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, i, j, ready_j, ack_j, btn_left;
    logic btn_lvl;

    for (int r = 0; r < 23; r++) begin
      int e;
      e = r - 2;
      por_tbl[r].rl    = (r >= 3);
      por_tbl[r].stage = (e >= 18) ? 4'b1111 : (e >= 16) ? 4'b0111 :
                         (e >= 14) ? 4'b0011 : (e >= 12) ? 4'b0001 : 4'b0000;
      por_tbl[r].ready = (e >= 18);
      por_tbl[r].cause = 2'b00;
    end

    bus.Btn_Reset_L  = 1'b1;
    bus.Sw_Reset_Req = 1'b0;
    #1;
    assert_reset();
    check("reset_state", {bus.Stage_Reset_L, bus.Ready, bus.Sw_Reset_Ack, bus.Reset_Cause, bus.Reset_Count}, 32'd0);
    @(negedge CLK);
    #1;

    // Power-on table
    for (int r = 0; r < 23; r++) begin
      Reset_L = por_tbl[r].rl;
      step(1'b1, 1'b0);
      check($sformatf("por_row%0d", r), {bus.Stage_Reset_L, bus.Ready, bus.Reset_Cause},
            {por_tbl[r].stage, por_tbl[r].ready, por_tbl[r].cause});
    end

    // Button: 9 lows do nothing
    for (i = 0; i < 9; i++) step(1'b0, 1'b0);
    for (i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("btn9_no_reset", {bus.Ready, bus.Reset_Count}, {1'b1, 8'd0});

    // Button held 50 cycles: one sequence, fired on the 10th synced-low edge
    i = 0;
    while (i < 20) begin
      step(1'b0, 1'b0);
      i++;
      if (!bus.Ready) break;
    end
    check("btn10_edge", i, 12);
    check("btn10_state", {bus.Stage_Reset_L, bus.Reset_Cause, bus.Reset_Count}, {4'b0000, 2'b01, 8'd1});
    for (; i < 50; i++) step(1'b0, 1'b0);
    check("btn50_single", {bus.Ready, bus.Reset_Count}, {1'b1, 8'd1});
    for (i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Software request in RUN
    step(1'b1, 1'b1);
    check("sw_accept", {bus.Sw_Reset_Ack, bus.Stage_Reset_L, bus.Ready, bus.Reset_Cause, bus.Reset_Count},
          {1'b1, 4'b0000, 1'b0, 2'b10, 8'd2});
    for (i = 0; i < 15; i++) step(1'b1, 1'b0);
    check("sw_release15", {bus.Stage_Reset_L, bus.Ready}, {4'b0111, 1'b0});
    step(1'b1, 1'b0);
    check("sw_release16", {bus.Stage_Reset_L, bus.Ready}, {4'b1111, 1'b1});

    // Software request raised during RELEASE waits for RUN
    step(1'b1, 1'b1);
    check("sw2_accept", {bus.Sw_Reset_Ack, bus.Reset_Count}, {1'b1, 8'd3});
    n = 0;
    while (bus.Stage_Reset_L != 4'b0001 && n < 20) begin
      step(1'b1, 1'b0);
      n++;
    end
    check("sw2_reach_release", bus.Stage_Reset_L, 4'b0001);
    ready_j = 0;
    ack_j   = 0;
    for (j = 1; j <= 30; j++) begin
      step(1'b1, 1'b1);
      if (bus.Ready && ready_j == 0) ready_j = j;
      if (bus.Sw_Reset_Ack) begin
        ack_j = j;
        break;
      end
    end
    check("pending_ack_edge", ack_j, 7);
    check("pending_ack_after_ready", ack_j, ready_j + 1);

    // Reset_L pulse mid-release
    n = 0;
    while (bus.Stage_Reset_L != 4'b0011 && n < 20) begin
      step(1'b1, 1'b0);
      n++;
    end
    check("mid_reach_0011", bus.Stage_Reset_L, 4'b0011);
    assert_reset();
    check("mid_async_clear", {bus.Stage_Reset_L, bus.Ready, bus.Reset_Cause, bus.Reset_Count}, 32'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    Reset_L = 1'b1;
    run_until_ready("mid_por_ready", 40, n);
    check("mid_por_latency", n, 2 + T_LAST);

    // Button and software request on the same edge
    for (i = 0; i < 11; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("both_accept", {bus.Sw_Reset_Ack, bus.Ready, bus.Reset_Cause, bus.Reset_Count},
          {1'b1, 1'b0, 2'b10, 8'd1});
    run_until_ready("both_ready", 40, n);
    check("both_single", bus.Reset_Count, 8'd1);

    // Count saturation
    for (int r = 0; r < 256; r++) begin
      step(1'b1, 1'b1);
      check("sat_ack", bus.Sw_Reset_Ack, 1'b1);
      run_until_ready("sat_ready", 40, n);
    end
    check("sat_count", {bus.Reset_Cause, bus.Reset_Count}, {2'b10, 8'd255});

    // Randomized run against the model
    btn_left = 0;
    btn_lvl  = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (btn_left == 0) begin
        btn_lvl  = ($urandom_range(0, 2) != 0);
        btn_left = $urandom_range(1, 14);
      end
      btn_left--;
      if ($urandom_range(0, 399) == 0) begin
        assert_reset();
        for (int r = 0; r < int'($urandom_range(1, 3)); r++) step(btn_lvl, 1'b0);
        Reset_L = 1'b1;
      end
      step(btn_lvl, ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
